// File: rtl/ws_fault_pkg.sv
// Shared types for the weight-stationary fault-injection sequencer:
// the campaign FSM encoding and the array drain length.
package ws_fault_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_DONE    = 2'd3
  } ws_state_e;

  // Cycles needed for the last activation to ripple out of an N x N array.
  function automatic int drain_len(input int n);
    return 2 * n;
  endfunction

endpackage

// File: rtl/ws_fault_sequencer_if.sv
// Array-side bus of the fault sequencer: weight/activation fetch, array feeds,
// per-PE fault mask and the golden/faulty column outputs coming back.
interface ws_fault_sequencer_if #(
  parameter int D_W   = 8,
  parameter int N     = 8,
  parameter int CNT_W = 16
);
  logic [CNT_W-1:0]       w_addr;
  logic [N*D_W-1:0]       w_data;
  logic [CNT_W-1:0]       a_addr;
  logic [N*D_W-1:0]       a_data;
  logic                   load_weight;
  logic [N*D_W-1:0]       m1;
  logic [N*D_W-1:0]       m0;
  logic [N*N*D_W-1:0]     fault_mask;
  logic [N*2*D_W-1:0]     m2_gold;
  logic [N*2*D_W-1:0]     m2_fault;

  modport master (
    output w_addr, a_addr, load_weight, m1, m0, fault_mask,
    input  w_data, a_data, m2_gold, m2_fault
  );

  modport slave (
    input  w_addr, a_addr, load_weight, m1, m0, fault_mask,
    output w_data, a_data, m2_gold, m2_fault
  );
endinterface

// File: rtl/ws_mismatch_tracker.sv
// Compares golden and faulty array columns each COMPUTE cycle, counting
// mismatching cycles (saturating) and latching the first mismatch location.
module ws_mismatch_tracker
  import ws_fault_pkg::*;
#(
  parameter int D_W   = 8,
  parameter int N     = 8,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 en,
  input  logic [CNT_W-1:0]     cyc,
  input  logic [N*2*D_W-1:0]   m2_gold,
  input  logic [N*2*D_W-1:0]   m2_fault,
  output logic [CNT_W-1:0]     mis_cnt,
  output logic [CNT_W-1:0]     first_cycle,
  output logic [CNT_W-1:0]     first_col,
  output logic                 first_valid
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic             mis_p0;
  logic [CNT_W-1:0] col_p0;

  // Descending scan so the lowest mismatching column is the one that sticks.
  always_comb begin
    mis_p0 = 1'b0;
    col_p0 = '0;
    for (int c = N - 1; c >= 0; c--) begin
      if (m2_gold[c*2*D_W +: 2*D_W] != m2_fault[c*2*D_W +: 2*D_W]) begin
        mis_p0 = 1'b1;
        col_p0 = CNT_W'(c);
      end
    end
  end

  // ---- result registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mis_cnt     <= '0;
      first_cycle <= '0;
      first_col   <= '0;
      first_valid <= 1'b0;
    end else if (clr) begin
      mis_cnt     <= '0;
      first_cycle <= '0;
      first_col   <= '0;
      first_valid <= 1'b0;
    end else if (en && mis_p0) begin
      mis_cnt <= sat_inc(mis_cnt);
      if (!first_valid) begin
        first_cycle <= cyc;
        first_col   <= col_p0;
        first_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ws_fault_sequencer.sv
// Weight-stationary fault campaign sequencer: loads weights, streams
// activations, drives a per-PE fault mask; WS_FAULT_COMPARE_EN adds result tracking.
module ws_fault_sequencer
  import ws_fault_pkg::*;
#(
  parameter int D_W   = 8,
  parameter int N     = 8,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CNT_W-1:0]     num_acts,
  input  logic                 flt_en,
  input  logic [CNT_W-1:0]     flt_row,
  input  logic [CNT_W-1:0]     flt_col,
  input  logic [CNT_W-1:0]     flt_cycle,
  input  logic [CNT_W-1:0]     flt_len,
  input  logic [D_W-1:0]       flt_val,
  ws_fault_sequencer_if.master arr,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     mis_cnt,
  output logic [CNT_W-1:0]     first_cycle,
  output logic [CNT_W-1:0]     first_col,
  output logic                 first_valid
);

  localparam logic [CNT_W:0] DRAIN     = (CNT_W+1)'(drain_len(N));
  localparam logic [CNT_W:0] LOAD_LAST = (CNT_W+1)'(N - 1);
  localparam logic [CNT_W:0] ONE       = (CNT_W+1)'(1);

  ws_state_e        st, st_nxt;
  logic [CNT_W:0]   cnt;
  logic [CNT_W-1:0] num_acts_q, flt_row_q, flt_col_q, flt_cycle_q, flt_len_q;
  logic             flt_en_q;
  logic [D_W-1:0]   flt_val_q;

  logic             start_acc, load_last, comp_last, act_live, flt_live;
  logic [CNT_W:0]   comp_len, flt_end, w_idx;

  assign start_acc = start && (st == ST_IDLE);
  // One extra bit so num_acts + 2N and flt_cycle + flt_len cannot wrap.
  assign comp_len  = {1'b0, num_acts_q} + DRAIN;
  assign flt_end   = {1'b0, flt_cycle_q} + {1'b0, flt_len_q};
  assign load_last = (cnt == LOAD_LAST);
  assign comp_last = ((cnt + ONE) == comp_len);
  assign w_idx     = LOAD_LAST - cnt;
  assign act_live  = (st == ST_COMPUTE) && (cnt < {1'b0, num_acts_q});
  assign flt_live  = flt_en_q && (st == ST_COMPUTE) && (cnt >= {1'b0, flt_cycle_q}) &&
                     ((flt_len_q == '0) || (cnt < flt_end));

  // ---- state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= ST_IDLE;
    else        st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    unique case (st)
      ST_IDLE:    if (start)     st_nxt = ST_LOAD;
      ST_LOAD:    if (load_last) st_nxt = ST_COMPUTE;
      ST_COMPUTE: if (comp_last) st_nxt = ST_DONE;
      ST_DONE:                   st_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = (st == ST_LOAD) || (st == ST_COMPUTE);
    done       = (st == ST_DONE);
    arr.w_addr = (st == ST_LOAD) ? w_idx[CNT_W-1:0] : '0;
    arr.a_addr = act_live ? cnt[CNT_W-1:0] : '0;
  end

  // ---- campaign counter and latched configuration ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      num_acts_q  <= '0;
      flt_en_q    <= 1'b0;
      flt_row_q   <= '0;
      flt_col_q   <= '0;
      flt_cycle_q <= '0;
      flt_len_q   <= '0;
      flt_val_q   <= '0;
    end else if (start_acc) begin
      cnt         <= '0;
      num_acts_q  <= num_acts;
      flt_en_q    <= flt_en;
      flt_row_q   <= flt_row;
      flt_col_q   <= flt_col;
      flt_cycle_q <= flt_cycle;
      flt_len_q   <= flt_len;
      flt_val_q   <= flt_val;
    end else begin
      unique case (st)
        ST_LOAD:    cnt <= load_last ? '0 : cnt + ONE;
        ST_COMPUTE: cnt <= cnt + ONE;
        default:    cnt <= '0;
      endcase
    end
  end

  // ---- array feed stage: data lands one cycle behind its address ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arr.load_weight <= 1'b0;
      arr.m1          <= '0;
      arr.m0          <= '0;
    end else begin
      arr.load_weight <= (st == ST_LOAD);
      arr.m1          <= (st == ST_LOAD) ? arr.w_data : '0;
      arr.m0          <= act_live ? arr.a_data : '0;
    end
  end

  // Out-of-range row/col never matches a loop index, so it yields no mask bit.
  always_comb begin
    arr.fault_mask = '0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (flt_live && (flt_row_q == CNT_W'(r)) && (flt_col_q == CNT_W'(c)))
          arr.fault_mask[(r*N+c)*D_W +: D_W] = flt_val_q;
      end
    end
  end

`ifdef WS_FAULT_COMPARE_EN
  ws_mismatch_tracker #(.D_W(D_W), .N(N), .CNT_W(CNT_W)) u_tracker (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (start_acc),
    .en          (st == ST_COMPUTE),
    .cyc         (cnt[CNT_W-1:0]),
    .m2_gold     (arr.m2_gold),
    .m2_fault    (arr.m2_fault),
    .mis_cnt     (mis_cnt),
    .first_cycle (first_cycle),
    .first_col   (first_col),
    .first_valid (first_valid)
  );
`else
  assign mis_cnt     = '0;
  assign first_cycle = '0;
  assign first_col   = '0;
  assign first_valid = 1'b0;
`endif

endmodule

// File: tb/tb_ws_fault_sequencer.sv
// Directed bench for ws_fault_sequencer (N=4): cycle-by-cycle sequencing,
// fault-mask windows, mismatch results, start masking and mid-run reset.
module tb_ws_fault_sequencer;
  localparam int D_W   = 8;
  localparam int N     = 4;
  localparam int CNT_W = 16;
  localparam int L     = N;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n, start, flt_en;
  logic [CNT_W-1:0] num_acts, flt_row, flt_col, flt_cycle, flt_len;
  logic [D_W-1:0]   flt_val;
  logic             busy, done, first_valid;
  logic [CNT_W-1:0] mis_cnt, first_cycle, first_col;
  logic [N*2*D_W-1:0] m2_fault_drv;

  localparam logic [N*2*D_W-1:0] GOLD = 64'h0123_4567_89AB_CDEF;

  ws_fault_sequencer_if #(.D_W(D_W), .N(N), .CNT_W(CNT_W)) arr ();

  ws_fault_sequencer #(.D_W(D_W), .N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_acts(num_acts),
    .flt_en(flt_en), .flt_row(flt_row), .flt_col(flt_col),
    .flt_cycle(flt_cycle), .flt_len(flt_len), .flt_val(flt_val),
    .arr(arr.master),
    .busy(busy), .done(done), .mis_cnt(mis_cnt), .first_cycle(first_cycle),
    .first_col(first_col), .first_valid(first_valid)
  );

  function automatic logic [N*D_W-1:0] wrow(input int i);
    return 32'h5060_7000 + 32'(i);
  endfunction

  function automatic logic [N*D_W-1:0] arow(input int i);
    return 32'hA0B0_C000 + 32'(i);
  endfunction

  // Weight and activation memories answer in the same cycle.
  always_comb begin
    arr.w_data   = wrow(int'(arr.w_addr));
    arr.a_data   = arow(int'(arr.a_addr));
    arr.m2_gold  = GOLD;
    arr.m2_fault = m2_fault_drv;
  end

  int n_vec = 0;
  int n_mis = 0;

  task automatic chk_vec(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string pfx);
    chk_vec({pfx, " busy"},        128'(busy), 128'(0));
    chk_vec({pfx, " done"},        128'(done), 128'(0));
    chk_vec({pfx, " load_weight"}, 128'(arr.load_weight), 128'(0));
    chk_vec({pfx, " w_addr"},      128'(arr.w_addr), 128'(0));
    chk_vec({pfx, " a_addr"},      128'(arr.a_addr), 128'(0));
    chk_vec({pfx, " m0"},          128'(arr.m0), 128'(0));
    chk_vec({pfx, " m1"},          128'(arr.m1), 128'(0));
    chk_vec({pfx, " fault_mask"},  arr.fault_mask, 128'(0));
    chk_vec({pfx, " mis_cnt"},     128'(mis_cnt), 128'(0));
    chk_vec({pfx, " first_valid"}, 128'(first_valid), 128'(0));
    chk_vec({pfx, " first_cycle"}, 128'(first_cycle), 128'(0));
    chk_vec({pfx, " first_col"},   128'(first_col), 128'(0));
  endtask

  // One campaign; k counts cycles after the accepted start, COMPUTE cyc = k - L.
  task automatic run(input string nm, input int na, input int fen, input int frow,
                     input int fcol, input int fcyc, input int flen, input int fval,
                     input int mmode, input int abort_c, input int poke);
    int c, cl;
    bit in_comp;
    logic [127:0] exp_mask;
    cl = na + 2 * N;
    @(negedge clk);
    num_acts  = CNT_W'(na);
    flt_en    = fen[0];
    flt_row   = CNT_W'(frow);
    flt_col   = CNT_W'(fcol);
    flt_cycle = CNT_W'(fcyc);
    flt_len   = CNT_W'(flen);
    flt_val   = D_W'(fval);
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    // Configuration must already be latched; scramble the inputs.
    num_acts = 16'd1; flt_en = 1'b1; flt_row = '0; flt_col = '0;
    flt_cycle = '0; flt_len = '0; flt_val = 8'hFF;
    for (int k = 0; k <= L + cl + 1; k++) begin
      c = k - L;
      in_comp = (k >= L) && (k < L + cl);
      if (k == 0) begin
        chk_vec({nm, " cleared mis_cnt"}, 128'(mis_cnt), 128'(0));
        chk_vec({nm, " cleared first_valid"}, 128'(first_valid), 128'(0));
      end
      if (abort_c >= 0 && in_comp && c == abort_c) begin
        rst_n = 1'b0;
        #1;
        chk_all_zero({nm, " abort"});
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          chk_vec({nm, " post-abort done"}, 128'(done), 128'(0));
          chk_vec({nm, " post-abort busy"}, 128'(busy), 128'(0));
        end
        return;
      end
      exp_mask = '0;
      if (fen != 0 && in_comp && c >= fcyc && (flen == 0 || c < fcyc + flen) &&
          frow < N && fcol < N)
        exp_mask[(frow*N+fcol)*D_W +: D_W] = D_W'(fval);
      chk_vec({nm, " busy"},        128'(busy), 128'(k < L + cl));
      chk_vec({nm, " done"},        128'(done), 128'(k == L + cl));
      chk_vec({nm, " load_weight"}, 128'(arr.load_weight), 128'(k >= 1 && k <= L));
      chk_vec({nm, " w_addr"},      128'(arr.w_addr), 128'((k < L) ? L - 1 - k : 0));
      chk_vec({nm, " a_addr"},      128'(arr.a_addr), 128'((in_comp && c < na) ? c : 0));
      chk_vec({nm, " m1"},          128'(arr.m1), 128'((k >= 1 && k <= L) ? wrow(L - k) : 32'h0));
      chk_vec({nm, " m0"},          128'(arr.m0),
              128'((in_comp && c >= 1 && c - 1 < na) ? arow(c - 1) : 32'h0));
      chk_vec({nm, " fault_mask"},  arr.fault_mask, exp_mask);
      start = (poke != 0 && k == 2);
      m2_fault_drv = GOLD;
      if (mmode != 0 && in_comp && c == 4) m2_fault_drv = GOLD ^ 64'h0001_0000_0000_0000;
      if (mmode != 0 && in_comp && c == 6) m2_fault_drv = GOLD ^ 64'h0001_0000_0001_0000;
      @(negedge clk);
    end
    start = 1'b0;
`ifdef WS_FAULT_COMPARE_EN
    chk_vec({nm, " mis_cnt"},     128'(mis_cnt),     128'(mmode != 0 ? 2 : 0));
    chk_vec({nm, " first_valid"}, 128'(first_valid), 128'(mmode != 0 ? 1 : 0));
    chk_vec({nm, " first_cycle"}, 128'(first_cycle), 128'(mmode != 0 ? 4 : 0));
    chk_vec({nm, " first_col"},   128'(first_col),   128'(mmode != 0 ? 3 : 0));
`else
    chk_vec({nm, " mis_cnt"},     128'(mis_cnt),     128'(0));
    chk_vec({nm, " first_valid"}, 128'(first_valid), 128'(0));
    chk_vec({nm, " first_cycle"}, 128'(first_cycle), 128'(0));
    chk_vec({nm, " first_col"},   128'(first_col),   128'(0));
`endif
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; num_acts = '0; flt_en = 1'b0;
    flt_row = '0; flt_col = '0; flt_cycle = '0; flt_len = '0; flt_val = '0;
    m2_fault_drv = GOLD;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    //  name        na fen row col cyc len val    mm abort poke
    run("basic",     3, 0,  0,  0,  0,  0, 'h00,  0, -1,   0);
    run("window",    3, 1,  1,  2,  5,  3, 'h10,  0, -1,   1);
    run("permanent", 3, 1,  0,  3,  2,  0, 'hA5,  0, -1,   0);
    run("row_oob",   3, 1,  4,  1,  0,  0, 'h3C,  0, -1,   0);
    run("mismatch",  5, 0,  0,  0,  0,  0, 'h00,  1, -1,   0);
    run("no_acts",   0, 1,  2,  0,  7,  0, 'h77,  0, -1,   0);
    run("abort",     6, 1,  3,  3,  1,  0, 'h5A,  0,  3,   0);
    run("after_rst", 3, 0,  0,  0,  0,  0, 'h00,  1, -1,   0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
